branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-side branch target buffer with 2-bit saturating counters. It consumes the branch-resolution record produced by the execute stage (`record_we`, `record_data`, `record_pc_result`) and predicts, for the PC being fetched, whether to redirect and where. Its prediction bit travels down the IF/ID register and returns to execute as `predict_ID`, closing the loop. The lookup is combinational; all table state is sequential.

## Interface
- `INDEX_W`, 4: index width; table holds 2^INDEX_W entries, direct-mapped.
- `CNT_INIT`, 2'b10: counter value written when an entry is allocated (weakly taken).

- `clk`  in  1  clock, all state updates on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `pc_IF`  in  32  PC currently being fetched.
- `predict_IF`  out  1  1 = predict taken/redirect.
- `pc_predict_IF`  out  32  next fetch PC: stored target if `predict_IF`, else `pc_IF + 4`.
- `record_we`  in  1  execute resolved a branch, or a jal that was not predicted.
- `record_data`  in  1  resolved direction; 1 = taken.
- `record_pc`  in  32  PC of the resolved instruction (its `pc_ID`).
- `record_pc_result`  in  32  resolved next PC; a valid target only when `record_data` = 1.
- `mispredict_EX`  in  1  execute redirected fetch (`pc_change_EX`).
- `stat_branch_cnt`  out  32  number of cycles with `record_we` = 1.
- `stat_mispredict_cnt`  out  32  number of cycles with `mispredict_EX` = 1.

## Operation
- Address split: index = `pc[INDEX_W+1:2]`, tag = `pc[31:INDEX_W+2]`. `pc[1:0]` is ignored.
- Entry fields: `valid` (1), `tag` (30-INDEX_W), `target` (32), `cnt` (2).
- Lookup (combinational on `pc_IF`):
  - hit = `valid && tag == pc_IF tag`.
  - `predict_IF` = hit && `cnt[1]`.
  - `pc_predict_IF` = `predict_IF` ? `target` : `pc_IF + 4`. The add wraps modulo 2^32.
- Update (on the clock edge when `record_we` = 1; the entry is the one indexed by `record_pc`):
  - Hit and taken: `cnt` increments, saturating at 3; `target` <= `record_pc_result`.
  - Hit and not taken: `cnt` decrements, saturating at 0; `target` is unchanged. `record_pc_result` is pc+4 in this case and must not be stored.
  - Miss and taken: allocate. Set `valid` = 1, write the new tag, `target` <= `record_pc_result`, `cnt` <= `CNT_INIT`. This overwrites any previous occupant.
  - Miss and not taken: no change; no allocation.
- Jal records arrive with `record_data` = 1 and follow the taken rules. Jalr never produces a record, so it is never allocated.
- A `valid` entry is never invalidated except by reset.
- Statistics:
  - `stat_branch_cnt` += 1 per cycle with `record_we`.
  - `stat_mispredict_cnt` += 1 per cycle with `mispredict_EX`.
  - Both wrap modulo 2^32 and are independent of each other.

## Timing
- Lookup latency: 0 cycles, purely combinational from `pc_IF` and table state.
- Update latency: 1 cycle. State written at edge N is visible to a lookup from cycle N+1.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update state. There is no bypass.
- One update per cycle at most. `record_we` may be asserted every cycle, including back-to-back records for the same PC; each applies in order.
- Reset (`rstn` = 0, asynchronous):
  - Every `valid` = 0, `cnt` = 0, `target` = 0, `tag` = 0.
  - Both stat counters = 0.
  - Outputs immediately become `predict_IF` = 0 and `pc_predict_IF` = `pc_IF + 4`.
  - A reset asserted mid-stream discards any pending update on that edge.
- While `rstn` = 0, `record_we` and `mispredict_EX` are ignored.
- Release of `rstn` is synchronised externally; the first update can occur on the first edge after release.

## Test plan
- Reset then lookup: `pc_IF` = 0x0000_0040 gives `predict_IF` = 0 and `pc_predict_IF` = 0x0000_0044. Both stat counters read 0.
- Allocate on taken:
  - Stimulus: `record_we` = 1, `record_data` = 1, `record_pc` = 0x40, `record_pc_result` = 0x100.
  - Next cycle: `pc_IF` = 0x40 gives `predict_IF` = 1 and `pc_predict_IF` = 0x100; `stat_branch_cnt` = 1.
- Counter hysteresis on 0x40, starting from the entry above (`cnt` = 2):
  - One not-taken record (`record_pc_result` = 0x44) gives `cnt` = 1 and `predict_IF` = 0, with `target` still 0x100.
  - Then three taken records give `cnt` 2, 3, 3 (saturates) and `predict_IF` = 1.
  - Then four not-taken records give `cnt` 2, 1, 0, 0 (saturates) and `predict_IF` = 0.
- Aliasing, with `INDEX_W` = 4 (both PCs map to index 0):
  - Stimulus: taken record for 0x40 with target 0x100, then taken record for 0x80 with target 0x200.
  - Lookup 0x40 gives `predict_IF` = 0 (tag miss), `pc_predict_IF` = 0x44.
  - Lookup 0x80 gives `predict_IF` = 1, `pc_predict_IF` = 0x200.
  - A not-taken record for 0x0C0 (miss) leaves the entry unchanged.
- Same-cycle read/write: in the cycle the first allocate of 0x40 is presented, `pc_IF` = 0x40 gives `predict_IF` = 0; the following cycle gives 1.
- Wrap and async reset:
  - `pc_IF` = 0xFFFF_FFFC on a miss gives `pc_predict_IF` = 0x0000_0000.
  - Pulse `mispredict_EX` 3 cycles, giving `stat_mispredict_cnt` = 3.
  - Drop `rstn` between edges: all outputs return to reset values without waiting for a clock edge, and earlier entries no longer hit.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side branch target buffer: direct-mapped, tagged, 2-bit saturating counters.
// Lookup is combinational on pc_IF; resolution records from execute update the table on clk.
module branch_predictor #(
  parameter int unsigned INDEX_W  = 4,
  parameter logic [1:0]  CNT_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc_IF,
  output logic        predict_IF,
  output logic [31:0] pc_predict_IF,
  input  logic        record_we,
  input  logic        record_data,
  input  logic [31:0] record_pc,
  input  logic [31:0] record_pc_result,
  input  logic        mispredict_EX,
  output logic [31:0] stat_branch_cnt,
  output logic [31:0] stat_mispredict_cnt
);

  localparam int unsigned DEPTH = 1 << INDEX_W;
  localparam int unsigned TAG_W = 30 - INDEX_W;

  logic              valid_q  [DEPTH];
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [31:0]       target_q [DEPTH];
  logic [1:0]        cnt_q    [DEPTH];

  logic [INDEX_W-1:0] if_idx;
  logic [TAG_W-1:0]   if_tag;
  logic               if_hit;
  logic [INDEX_W-1:0] rec_idx;
  logic [TAG_W-1:0]   rec_tag;
  logic               rec_hit;

  // Instructions are word aligned; the byte-offset bits never take part in lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_IF[1:0], record_pc[1:0]};

  always_comb begin
    if_idx        = pc_IF[INDEX_W+1:2];
    if_tag        = pc_IF[31:INDEX_W+2];
    if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    predict_IF    = if_hit && cnt_q[if_idx][1];
    pc_predict_IF = predict_IF ? target_q[if_idx] : pc_IF + 32'd4;
  end

  always_comb begin
    rec_idx = record_pc[INDEX_W+1:2];
    rec_tag = record_pc[31:INDEX_W+2];
    rec_hit = valid_q[rec_idx] && (tag_q[rec_idx] == rec_tag);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else if (record_we) begin
      if (rec_hit) begin
        if (record_data) begin
          if (cnt_q[rec_idx] != 2'b11) cnt_q[rec_idx] <= cnt_q[rec_idx] + 2'd1;
          target_q[rec_idx] <= record_pc_result;
        end else if (cnt_q[rec_idx] != 2'b00) begin
          // Not-taken result is just pc+4; the stored target is kept for later taken hits.
          cnt_q[rec_idx] <= cnt_q[rec_idx] - 2'd1;
        end
      end else if (record_data) begin
        valid_q[rec_idx]  <= 1'b1;
        tag_q[rec_idx]    <= rec_tag;
        target_q[rec_idx] <= record_pc_result;
        cnt_q[rec_idx]    <= CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_branch_cnt     <= '0;
      stat_mispredict_cnt <= '0;
    end else begin
      if (record_we)     stat_branch_cnt     <= stat_branch_cnt + 32'd1;
      if (mispredict_EX) stat_mispredict_cnt <= stat_mispredict_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, hand-written
// reset/statistics sequences, then random traffic against an array-based model.
module tb_branch_predictor;

  logic        clk;
  logic        rstn;
  logic [31:0] pc_IF;
  logic        predict_IF;
  logic [31:0] pc_predict_IF;
  logic        record_we;
  logic        record_data;
  logic [31:0] record_pc;
  logic [31:0] record_pc_result;
  logic        mispredict_EX;
  logic [31:0] stat_branch_cnt;
  logic [31:0] stat_mispredict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor #(.INDEX_W(4), .CNT_INIT(2'b10)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .pc_IF               (pc_IF),
    .predict_IF          (predict_IF),
    .pc_predict_IF       (pc_predict_IF),
    .record_we           (record_we),
    .record_data         (record_data),
    .record_pc           (record_pc),
    .record_pc_result    (record_pc_result),
    .mispredict_EX       (mispredict_EX),
    .stat_branch_cnt     (stat_branch_cnt),
    .stat_mispredict_cnt (stat_mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        data;
    logic [31:0] rpc;
    logic [31:0] res;
    logic [31:0] pc;
    logic        exp_pred;
    logic [31:0] exp_npc;
  } vec_t;

  vec_t vecs[$];

  // Reference model: 16-entry table addressed by arithmetic on the PC.
  bit          m_valid  [16];
  int unsigned m_tag    [16];
  logic [31:0] m_target [16];
  int          m_cnt    [16];
  int unsigned m_branches;
  int unsigned m_mispredicts;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic we, input logic data, input logic [31:0] rpc,
                     input logic [31:0] res, input logic [31:0] pc,
                     input logic exp_pred, input logic [31:0] exp_npc);
    vec_t v;
    v.we = we; v.data = data; v.rpc = rpc; v.res = res; v.pc = pc;
    v.exp_pred = exp_pred; v.exp_npc = exp_npc;
    vecs.push_back(v);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0; m_cnt[i] = 0;
    end
    m_branches = 0;
    m_mispredicts = 0;
  endtask

  task automatic model_lookup(input logic [31:0] pc, output logic pred, output logic [31:0] npc);
    int unsigned idx;
    idx  = (pc / 4) % 16;
    pred = m_valid[idx] && (m_tag[idx] == pc / 64) && (m_cnt[idx] >= 2);
    npc  = pred ? m_target[idx] : pc + 32'd4;
  endtask

  task automatic model_update();
    int unsigned idx;
    bit hit;
    idx = (record_pc / 4) % 16;
    hit = m_valid[idx] && (m_tag[idx] == record_pc / 64);
    if (record_we) begin
      m_branches++;
      if (hit && record_data) begin
        m_cnt[idx] = (m_cnt[idx] + 1 > 3) ? 3 : m_cnt[idx] + 1;
        m_target[idx] = record_pc_result;
      end else if (hit) begin
        m_cnt[idx] = (m_cnt[idx] - 1 < 0) ? 0 : m_cnt[idx] - 1;
      end else if (record_data) begin
        m_valid[idx] = 1; m_tag[idx] = record_pc / 64;
        m_target[idx] = record_pc_result; m_cnt[idx] = 2;
      end
    end
    if (mispredict_EX) m_mispredicts++;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    if ($urandom_range(0, 3) != 0)
      p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
          | 32'($urandom_range(0, 3));
    else
      p = $urandom;
    return p;
  endfunction

  task automatic apply_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    logic        e_pred;
    logic [31:0] e_npc;
    int unsigned n_rec;

    rstn = 1'b0; pc_IF = '0; record_we = 0; record_data = 0;
    record_pc = '0; record_pc_result = '0; mispredict_EX = 0;
    apply_reset();

    pc_IF = 32'h40;
    #1;
    check("reset_pred", 32'(predict_IF), 32'd0);
    check("reset_npc", pc_predict_IF, 32'h44);
    check("reset_branch_cnt", stat_branch_cnt, 32'd0);
    check("reset_mispredict_cnt", stat_mispredict_cnt, 32'd0);

    // Outputs are checked before the edge, so each row sees the state left by earlier rows.
    add(1, 1, 32'h40, 32'h100, 32'h40, 0, 32'h44);
    add(0, 0, 32'h0,  32'h0,   32'h40, 1, 32'h100);
    add(1, 0, 32'h40, 32'h44,  32'h40, 1, 32'h100);
    add(1, 1, 32'h40, 32'h100, 32'h40, 0, 32'h44);
    add(1, 1, 32'h40, 32'h100, 32'h40, 1, 32'h100);
    add(1, 1, 32'h40, 32'h100, 32'h40, 1, 32'h100);
    add(1, 0, 32'h40, 32'h44,  32'h40, 1, 32'h100);
    add(1, 0, 32'h40, 32'h44,  32'h40, 1, 32'h100);
    add(1, 0, 32'h40, 32'h44,  32'h40, 0, 32'h44);
    add(1, 0, 32'h40, 32'h44,  32'h40, 0, 32'h44);
    add(1, 1, 32'h40, 32'h100, 32'h40, 0, 32'h44);
    add(0, 0, 32'h0,  32'h0,   32'h40, 0, 32'h44);
    add(1, 1, 32'h80, 32'h200, 32'h80, 0, 32'h84);
    add(0, 0, 32'h0,  32'h0,   32'h40, 0, 32'h44);
    add(1, 0, 32'hC0, 32'hC4,  32'h80, 1, 32'h200);
    add(0, 0, 32'h0,  32'h0,   32'h80, 1, 32'h200);
    add(0, 0, 32'h0,  32'h0,   32'hC0, 0, 32'hC4);
    add(0, 0, 32'h0,  32'h0,   32'hFFFF_FFFC, 0, 32'h0);
    add(1, 1, 32'h80, 32'h300, 32'h80, 1, 32'h200);
    add(0, 0, 32'h0,  32'h0,   32'h80, 1, 32'h300);

    n_rec = 0;
    foreach (vecs[i]) begin
      record_we = vecs[i].we; record_data = vecs[i].data;
      record_pc = vecs[i].rpc; record_pc_result = vecs[i].res;
      pc_IF = vecs[i].pc;
      #1;
      check($sformatf("vec%0d_pred", i), 32'(predict_IF), 32'(vecs[i].exp_pred));
      check($sformatf("vec%0d_npc", i), pc_predict_IF, vecs[i].exp_npc);
      check($sformatf("vec%0d_branch_cnt", i), stat_branch_cnt, n_rec);
      if (vecs[i].we) n_rec++;
      tick();
    end
    record_we = 0;

    mispredict_EX = 1;
    tick(); tick(); tick();
    mispredict_EX = 0;
    #1;
    check("mispredict_cnt", stat_mispredict_cnt, 32'd3);
    check("branch_cnt_total", stat_branch_cnt, n_rec);

    // Asynchronous reset between edges, with a taken record pending.
    pc_IF = 32'h80;
    #1;
    check("pre_reset_pred", 32'(predict_IF), 32'd1);
    record_we = 1; record_data = 1; record_pc = 32'hC0; record_pc_result = 32'h500;
    mispredict_EX = 1;
    #1;
    rstn = 1'b0;
    #1;
    check("async_pred", 32'(predict_IF), 32'd0);
    check("async_npc", pc_predict_IF, 32'h84);
    check("async_branch_cnt", stat_branch_cnt, 32'd0);
    check("async_mispredict_cnt", stat_mispredict_cnt, 32'd0);
    tick();
    record_we = 0; mispredict_EX = 0;
    rstn = 1'b1;
    pc_IF = 32'hC0;
    #1;
    check("post_reset_no_alloc", pc_predict_IF, 32'hC4);
    pc_IF = 32'h80;
    #1;
    check("post_reset_old_entry", 32'(predict_IF), 32'd0);
    check("post_reset_branch_cnt", stat_branch_cnt, 32'd0);

    apply_reset();
    model_reset();
    for (int k = 0; k < 600; k++) begin
      pc_IF = rand_pc();
      record_we = ($urandom_range(0, 3) != 0);
      record_data = $urandom_range(0, 1);
      record_pc = rand_pc();
      record_pc_result = record_data ? ($urandom & 32'hFFFF_FFFC) : record_pc + 32'd4;
      mispredict_EX = ($urandom_range(0, 4) == 0);
      #1;
      model_lookup(pc_IF, e_pred, e_npc);
      check("rand_pred", 32'(predict_IF), 32'(e_pred));
      check("rand_npc", pc_predict_IF, e_npc);
      check("rand_branch_cnt", stat_branch_cnt, m_branches);
      check("rand_mispredict_cnt", stat_mispredict_cnt, m_mispredicts);
      model_update();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
